// File: rtl/word_serializer.sv
// Parallel-to-serial unloader: captures one wide word and offers its slices,
// highest slice first, on a narrow valid/ready stream.
module word_serializer #(
    parameter int data_size    = 8,
    parameter int memory_depth = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  load,
    input  logic [data_size*memory_depth-1:0]     data_in,
    output logic [data_size-1:0]                  data_out,
    output logic                                  valid,
    input  logic                                  ready,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(memory_depth+1)-1:0]     words_left
);

    localparam int WIDTH   = data_size * memory_depth;
    localparam int COUNT_W = $clog2(memory_depth + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WIDTH-1:0]    hold_reg;
    logic                transfer;
    logic                last_transfer;

    assign transfer      = (state == SEND) && ready;
    assign last_transfer = transfer && (words_left == COUNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load)          next_state = SEND;
            SEND:    if (last_transfer) next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // The holding register shifts toward its top on every transfer, so the
    // slice on offer is always the top one and reads zero once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg   <= '0;
            words_left <= '0;
            done       <= 1'b0;
        end else begin
            done <= last_transfer;
            if ((state == IDLE) && load) begin
                hold_reg   <= data_in;
                words_left <= COUNT_W'(memory_depth);
            end else if (transfer) begin
                hold_reg   <= hold_reg << data_size;
                words_left <= words_left - COUNT_W'(1);
            end
        end
    end

    always_comb begin
        valid    = (state == SEND);
        busy     = (state == SEND);
        data_out = hold_reg[WIDTH-1 -: data_size];
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: a default-size instance for the basic unload and a
// four-slice instance checked cycle by cycle against a scoreboard model.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        load_a;
    logic [15:0] data_in_a;
    logic [7:0]  data_out_a;
    logic        valid_a, ready_a, busy_a, done_a;
    logic [1:0]  words_left_a;

    logic        load_b;
    logic [31:0] data_in_b;
    logic [7:0]  data_out_b;
    logic        valid_b, ready_b, busy_b, done_b;
    logic [2:0]  words_left_b;

    int          check_count = 0;
    int          error_count = 0;

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_wl = 0;
    logic [31:0] cap = '0;
    logic [31:0] last_word = '0;
    logic        rand_ready = 1'b0;

    word_serializer dut_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .data_in(data_in_a),
        .data_out(data_out_a), .valid(valid_a), .ready(ready_a),
        .busy(busy_a), .done(done_a), .words_left(words_left_a)
    );

    word_serializer #(.data_size(8), .memory_depth(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .data_in(data_in_b),
        .data_out(data_out_b), .valid(valid_b), .ready(ready_b),
        .busy(busy_b), .done(done_b), .words_left(words_left_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model for dut_b: compares the current cycle, then predicts the
    // effect of the coming edge from the inputs that are stable right now.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_b.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_wl   = 0;
        end else begin
            checkOutput("b_valid", valid_b, m_busy);
            checkOutput("b_busy", busy_b, m_busy);
            checkOutput("b_done", done_b, m_done);
            checkOutput("b_words_left", words_left_b, m_wl);
            if (m_busy) checkOutput("b_data_out", data_out_b, q_b[0]);
            if (done_b) checkOutput("b_loopback", cap, last_word);
            m_done = 1'b0;
            if (m_busy && ready_b) begin
                cap = {cap[23:0], data_out_b};
                void'(q_b.pop_front());
                m_wl--;
                if (m_wl == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (!m_busy && load_b) begin
                for (int i = 3; i >= 0; i--) q_b.push_back(data_in_b[i*8 +: 8]);
                m_wl      = 4;
                m_busy    = 1'b1;
                last_word = data_in_b;
                cap       = '0;
            end
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            if (!busy_b) return;
            if (rand_ready) ready_b = ($urandom_range(0, 3) != 0);
            @(posedge clk) #1;
        end
        checkOutput("b_idle_timeout", 1, 0);
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        waitIdle();
        if (rand_ready) ready_b = ($urandom_range(0, 3) != 0);
        load_b    = 1'b1;
        data_in_b = word;
        @(posedge clk) #1;
        load_b    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        rst_n     = 1'b0;
        load_a    = 1'b0;
        data_in_a = '0;
        ready_a   = 1'b1;
        load_b    = 1'b0;
        data_in_b = '0;
        ready_b   = 1'b1;
        #12 rst_n = 1'b1;

        $display("[TB] reset and idle");
        repeat (10) begin
            @(negedge clk);
            checkOutput("a_idle", {valid_a, busy_a, done_a, data_out_a, words_left_a}, 0);
        end

        $display("[TB] basic unload, two slices");
        @(posedge clk) #1;
        data_in_a = 16'hA55A;
        load_a    = 1'b1;
        q_a.push_back(8'hA5);
        q_a.push_back(8'h5A);
        @(posedge clk) #1;
        load_a = 1'b0;
        @(negedge clk);
        checkOutput("a_valid_first", valid_a, 1);
        checkOutput("a_wl_first", words_left_a, 2);
        checkOutput("a_slice_first", data_out_a, q_a.pop_front());
        @(negedge clk);
        checkOutput("a_valid_second", valid_a, 1);
        checkOutput("a_wl_second", words_left_a, 1);
        checkOutput("a_slice_second", data_out_a, q_a.pop_front());
        @(negedge clk);
        checkOutput("a_done_pulse", {done_a, valid_a, busy_a, words_left_a}, 5'b10000);
        @(negedge clk);
        checkOutput("a_done_end", {done_a, valid_a}, 0);

        $display("[TB] backpressure and loads while busy");
        @(posedge clk) #1;
        data_in_b = 32'h11223344;
        load_b    = 1'b1;
        ready_b   = 1'b0;
        @(posedge clk) #1;
        load_b    = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ready_b = pat[i][0];
            load_b  = (i == 2) || (i == 6);
            data_in_b = (i == 2) ? 32'hDEADBEEF : 32'h55555555;
            @(posedge clk) #1;
        end
        load_b    = 1'b1;
        data_in_b = 32'hCAFEF00D;
        ready_b   = 1'b1;
        @(posedge clk) #1;
        load_b    = 1'b0;
        waitIdle();

        $display("[TB] async reset mid-transfer");
        applyStimulus(32'h01020304);
        @(posedge clk) #2;
        rst_n = 1'b0;
        #1;
        checkOutput("b_async_reset", {valid_b, busy_b, done_b, data_out_b, words_left_b}, 0);
        checkOutput("a_async_reset", {valid_a, busy_a, done_a, data_out_a, words_left_a}, 0);
        @(negedge clk);
        @(posedge clk) #1;
        rst_n = 1'b1;
        applyStimulus(32'hA1B2C3D4);
        waitIdle();

        $display("[TB] loopback with random data and backpressure");
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) applyStimulus($urandom);
        waitIdle();
        rand_ready = 1'b0;
        ready_b    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("b_scoreboard_drained", q_b.size(), 0);
        checkOutput("a_scoreboard_drained", q_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial unloader: the transmit-side counterpart of the team's parallel-capture shift register.
- Accepts one wide word of memory_depth slices and presents the slices one at a time on a data_size bus with a valid/ready handshake.
- Slice order lets a downstream shift register, strobed once per accepted word, rebuild the original wide bus bit-exact.
- Sits between a block producing wide results and any narrow word-at-a-time consumer.

Parameters:
data_size, 8, width of one output word in bits
memory_depth, 2, number of slices per wide word (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  request to capture data_in; honoured only in IDLE
data_in  input  data_size*memory_depth  wide word; slice i = bits [(i+1)*data_size-1 : i*data_size]
data_out  output  data_size  current slice being offered
valid  output  1  data_out holds a slice not yet accepted
ready  input  1  consumer accepts data_out on a clk edge where valid && ready
busy  output  1  high in SEND (load ignored)
done  output  1  one-cycle pulse, registered, the cycle after the final slice transfers
words_left  output  clog2(memory_depth+1)  slices not yet transferred

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE; holding register=0; data_out=0; valid=0; busy=0; done=0; words_left=0. A transfer in progress is abandoned with no done pulse.
- Transfer definition: a clk edge with valid && ready.
- IDLE:
  - valid=0; busy=0.
  - load=1 at an edge: capture data_in into the holding register; words_left<=memory_depth; go to SEND.
  - data_out becomes slice memory_depth-1 immediately after that edge (1-cycle load-to-valid latency).
- SEND:
  - valid=1; busy=1.
  - data_out = slice (words_left-1), so the highest slice goes first and slice 0 goes last. A downstream shift register then ends with slice 0 in its position 0.
  - On each transfer, words_left decrements and data_out advances to the next lower slice on the same edge.
  - With ready held high, back-to-back transfers occur every cycle.
  - ready low: data_out, valid and words_left hold stable (no slice dropped or repeated).
  - load in SEND is ignored; data_in changes do not affect the captured word.
  - On the transfer where words_left==1: words_left<=0, valid<=0, state<=IDLE, done<=1 for exactly the next cycle.
- Load timing around the final transfer:
  - load asserted in the same cycle as the final transfer is ignored (state is still SEND).
  - load asserted in the done cycle is accepted (state is IDLE), giving a 1-cycle bubble between words.
- memory_depth=1: a single transfer, then done; words_left counts 1 to 0.
- ready is a don't-care in IDLE. valid never asserts in IDLE.
- done and busy are never high in the same cycle.
- Outputs are registered; no combinational path from ready or load to any output.

Test Plan:
1. Reset/idle: reset, then hold load=0 and ready=1 for 10 cycles -> valid=0, busy=0, done=0, data_out=0, words_left=0 throughout.
2. Basic unload (defaults): load data_in=16'hA55A with ready=1 -> next cycle valid=1 and data_out=8'hA5; following cycle data_out=8'h5A; then valid=0 and done pulses for 1 cycle; 2 transfers total.
3. Backpressure (memory_depth=4): load 32'h11223344, ready toggling 1,0,0,1,0,1,1 -> accepted sequence is exactly 11,22,33,44; data_out stable while ready=0; words_left steps 4,3,2,1,0.
4. Load while busy: during test 3, pulse load with data_in=32'hDEADBEEF mid-transfer -> ignored, output stream unchanged. Load 32'hCAFEF00D in the done cycle -> CA,FE,F0,0D follow after a 1-cycle bubble.
5. Async reset mid-transfer: assert rst_n=0 between edges after the first of 4 slices -> all outputs 0 immediately, no done; after release, a new load streams from its top slice.
6. Loopback: connect data_out to a capture shift register strobed on valid && ready (memory_depth=4, random data_in, 100 words) -> reconstructed bus equals data_in after each done.
